// File: rtl/regfile_sb_pkg.sv
// Shared CPU definitions: write/load-extension modes used by the register
// file and the load/store unit.
package regfile_sb_pkg;

  typedef enum logic [2:0] {
    WM_NONE = 3'b000,
    WM_WORD = 3'b001,
    WM_LH   = 3'b010,
    WM_LB   = 3'b011,
    WM_LHU  = 3'b110,
    WM_LBU  = 3'b111
  } wr_mode_e;

  // 100/101 are reserved and behave as "no write".
  function automatic logic is_write(input logic [2:0] mode);
    case (mode)
      WM_WORD, WM_LH, WM_LB, WM_LHU, WM_LBU: is_write = 1'b1;
      default:                              is_write = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Write, read and scoreboard bus of the register file.
interface regfile_sb_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_RD        = 2
);
  logic [2:0]                    WE3;
  logic [ADDRESS_WIDTH-1:0]      A3;
  logic [DATA_WIDTH-1:0]         WD3;
  logic [NUM_RD*ADDRESS_WIDTH-1:0] RA;
  logic [NUM_RD*DATA_WIDTH-1:0]  RD;
  logic [NUM_RD-1:0]             hazard;
  logic                          sb_set;
  logic [ADDRESS_WIDTH-1:0]      sb_addr;
  logic                          ready;
  logic [DATA_WIDTH-1:0]         a0;

  modport master (
    output WE3, A3, WD3, RA, sb_set, sb_addr,
    input  RD, hazard, ready, a0
  );
  modport slave (
    input  WE3, A3, WD3, RA, sb_set, sb_addr,
    output RD, hazard, ready, a0
  );
endinterface

// File: rtl/regfile_sb_load_ext.sv
// Load extension: sign/zero-extends the byte or halfword field of a write.
module load_ext
  import regfile_sb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            mode,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  always_comb begin
    dout = '0;
    case (wr_mode_e'(mode))
      WM_WORD: dout = din;
      WM_LH:   dout = {{(DATA_WIDTH-16){din[15]}}, din[15:0]};
      WM_LB:   dout = {{(DATA_WIDTH-8){din[7]}}, din[7:0]};
      WM_LHU:  dout = {{(DATA_WIDTH-16){1'b0}}, din[15:0]};
      WM_LBU:  dout = {{(DATA_WIDTH-8){1'b0}}, din[7:0]};
      default: dout = '0;
    endcase
  end
endmodule

// File: rtl/regfile_sb.sv
// Register file with load scoreboard: zeroing sweep after reset, write-through
// read bypass and per-register pending-load hazard flags.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_RD        = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 2**ADDRESS_WIDTH;
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);

  logic [0:0]               state;
  logic [ADDRESS_WIDTH-1:0] idx;
  logic [DEPTH-1:0]         busy;
  logic [DATA_WIDTH-1:0]    rf [DEPTH];
  logic [DATA_WIDTH-1:0]    wd_ext;
  logic                     ready, wr_ok;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_arr;

  load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
    .mode (bus.WE3),
    .din  (bus.WD3),
    .dout (wd_ext)
  );

  assign ready = (state == S_RUN);
  assign wr_ok = ready && is_write(bus.WE3) && (bus.A3 != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
      idx   <= '0;
      busy  <= '0;
    end else if (state == S_CLEAR) begin
      idx <= idx + 1'b1;
      if (&idx) state <= S_RUN;
    end else begin
      if (wr_ok) busy[bus.A3] <= 1'b0;
      // Placed after the clear so a same-cycle set takes priority.
      if (bus.sb_set && bus.sb_addr != '0) busy[bus.sb_addr] <= 1'b1;
    end
  end

  // Storage carries no reset; the sweep is the only zeroing path.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) rf[idx] <= '0;
    else if (wr_ok)       rf[bus.A3] <= wd_ext;
  end

  function automatic logic [DATA_WIDTH-1:0] rd_mux(input logic [ADDRESS_WIDTH-1:0] a);
    if (!ready || a == '0)        rd_mux = '0;
    else if (wr_ok && a == bus.A3) rd_mux = wd_ext;
    else                           rd_mux = rf[a];
  endfunction

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] ra;
    assign ra = bus.RA[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    always_comb begin
      rd_arr[k] = rd_mux(ra);
      bus.hazard[k] = ready && (ra != '0) && busy[ra] && !(wr_ok && ra == bus.A3);
    end
  end

  assign bus.RD    = rd_arr;
  assign bus.ready = ready;
  assign bus.a0    = rd_mux(A0_IDX);
endmodule

// File: tb/tb_regfile_sb.sv
// Directed + random checks of regfile_sb against a behavioural register model.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  regfile_sb_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2)) bus ();

  regfile_sb #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: registers, pending-load flags, edges left in the clearing sweep.
  logic [31:0] mdl [32];
  bit          mbusy [32];
  int          m_left;
  logic [31:0] obs_rd0, obs_rd1;
  logic [1:0]  obs_hz;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [2:0] we, input logic [31:0] wd);
    case (we)
      3'd1:    return wd;
      3'd2:    return wd[15] ? (32'hFFFF_0000 | wd[15:0]) : {16'h0, wd[15:0]};
      3'd3:    return wd[7]  ? (32'hFFFF_FF00 | wd[7:0])  : {24'h0, wd[7:0]};
      3'd6:    return {16'h0, wd[15:0]};
      3'd7:    return {24'h0, wd[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_wr(input logic [2:0] we, input logic [4:0] a3);
    return (m_left == 0) && (we inside {3'd1, 3'd2, 3'd3, 3'd6, 3'd7}) && (a3 != 0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic vw,
                                        input logic [4:0] a3, input logic [31:0] ex);
    if (m_left != 0 || a == 0) return 32'h0;
    if (vw && a == a3)         return ex;
    return mdl[a];
  endfunction

  function automatic logic exp_hz(input logic [4:0] a, input logic vw, input logic [4:0] a3);
    return (m_left == 0) && (a != 0) && mbusy[a] && !(vw && a == a3);
  endfunction

  // One clock: drive just after the edge, check mid-cycle, then advance the model.
  task automatic cyc(input logic [2:0] we, input logic [4:0] a3, input logic [31:0] wd,
                     input logic [4:0] r0, input logic [4:0] r1,
                     input logic sbs, input logic [4:0] sba);
    logic vw;
    logic [31:0] ex;
    bus.WE3 = we; bus.A3 = a3; bus.WD3 = wd;
    bus.RA = {r1, r0}; bus.sb_set = sbs; bus.sb_addr = sba;
    #4;
    ex = ref_ext(we, wd);
    vw = exp_wr(we, a3);
    obs_rd0 = bus.RD[31:0];
    obs_rd1 = bus.RD[63:32];
    obs_hz  = bus.hazard;
    chk("ready", {31'h0, bus.ready}, {31'h0, m_left == 0});
    chk("rd0",   obs_rd0, exp_rd(r0, vw, a3, ex));
    chk("rd1",   obs_rd1, exp_rd(r1, vw, a3, ex));
    chk("hz0",   {31'h0, obs_hz[0]}, {31'h0, exp_hz(r0, vw, a3)});
    chk("hz1",   {31'h0, obs_hz[1]}, {31'h0, exp_hz(r1, vw, a3)});
    chk("a0",    bus.a0, exp_rd(5'd10, vw, a3, ex));
    @(posedge clk); #1;
    if (m_left != 0) begin
      m_left--;
      if (m_left == 0) foreach (mdl[i]) mdl[i] = 32'h0;
    end else begin
      if (vw) begin mdl[a3] = ex; mbusy[a3] = 1'b0; end
      if (sbs && sba != 0) mbusy[sba] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'd0, 5'd0, 32'h0, 5'd10, 5'd10, 1'b0, 5'd0);
  endtask

  // Async reset from mid-cycle; outputs must drop before any clock edge.
  task automatic do_rst();
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", {31'h0, bus.ready}, 32'h0);
    chk("rst_rd",    bus.RD[31:0], 32'h0);
    chk("rst_hz",    {30'h0, bus.hazard}, 32'h0);
    chk("rst_a0",    bus.a0, 32'h0);
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_left = 32;
  endtask

  initial begin
    logic [2:0] modes [5];
    logic [31:0] exps [5];
    modes = '{3'd3, 3'd7, 3'd2, 3'd6, 3'd1};
    exps  = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_8081, 32'h0000_8081, 32'h0000_8081};
    bus.WE3 = 3'd0; bus.A3 = '0; bus.WD3 = '0; bus.RA = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0;
    foreach (mdl[i]) begin mdl[i] = 32'h0; mbusy[i] = 1'b0; end
    @(posedge clk); #1;
    chk("por_ready", {31'h0, bus.ready}, 32'h0);
    chk("por_rd",    bus.RD[63:32], 32'h0);
    rst = 1'b0;
    m_left = 32;

    // Sweep: ready low for exactly 32 cycles; writes and sb_set ignored.
    cyc(3'd1, 5'd4, 32'hCAFE_F00D, 5'd4, 5'd4, 1'b1, 5'd4);
    idle(30);
    cyc(3'd1, 5'd4, 32'h1111_2222, 5'd4, 5'd0, 1'b1, 5'd4);
    chk("sweep_end", {31'h0, bus.ready}, 32'h1);
    cyc(3'd0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 5'd0);
    chk("clr_rd_x4", obs_rd0, 32'h0);
    chk("clr_hz_x4", {30'h0, obs_hz}, 32'h0);

    // Extension modes on x5.
    for (int i = 0; i < 5; i++) begin
      cyc(modes[i], 5'd5, 32'h0000_8081, 5'd0, 5'd0, 1'b0, 5'd0);
      cyc(3'd0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0);
      chk("ext_x5", obs_rd0, exps[i]);
    end

    // x0 stays zero; same-cycle bypass.
    cyc(3'd1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, 5'd0);
    cyc(3'd0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    chk("x0_zero", obs_rd0, 32'h0);
    cyc(3'd1, 5'd7, 32'h1234_5678, 5'd7, 5'd0, 1'b0, 5'd0);
    chk("bypass_x7", obs_rd0, 32'h1234_5678);

    // Scoreboard on x9.
    cyc(3'd0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b1, 5'd9);
    chk("sb_set_same", {31'h0, obs_hz[1]}, 32'h0);
    cyc(3'd0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b0, 5'd0);
    chk("sb_pending", {31'h0, obs_hz[1]}, 32'h1);
    cyc(3'd1, 5'd9, 32'h0000_0099, 5'd0, 5'd9, 1'b0, 5'd0);
    chk("sb_wr_bypass", {31'h0, obs_hz[1]}, 32'h0);
    cyc(3'd0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b0, 5'd0);
    chk("sb_cleared", {31'h0, obs_hz[1]}, 32'h0);
    cyc(3'd1, 5'd9, 32'h0000_0077, 5'd0, 5'd0, 1'b1, 5'd9);
    cyc(3'd0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    chk("sb_set_wins", {30'h0, obs_hz}, 32'h3);

    // Random traffic, biased toward a small register set to hit collisions.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] a3, r0, r1, sba;
      a3  = 5'($urandom_range(0, 12));
      r0  = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 12));
      r1  = ($urandom_range(0, 4) == 0) ? r0 : 5'($urandom_range(0, 31));
      sba = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 12));
      cyc(3'($urandom), a3, $urandom, r0, r1, 1'($urandom_range(0, 3) == 0), sba);
    end

    // Reset in RUN and again mid-sweep.
    cyc(3'd1, 5'd10, 32'd5, 5'd10, 5'd3, 1'b1, 5'd3);
    cyc(3'd0, 5'd0, 32'h0, 5'd10, 5'd3, 1'b0, 5'd0);
    chk("a0_is_5", bus.a0, 32'd5);
    do_rst();
    idle(10);
    do_rst();
    idle(31);
    chk("resweep_low", {31'h0, bus.ready}, 32'h0);
    cyc(3'd0, 5'd0, 32'h0, 5'd10, 5'd3, 1'b0, 5'd0);
    cyc(3'd0, 5'd0, 32'h0, 5'd10, 5'd3, 1'b0, 5'd0);
    chk("resweep_a0", obs_rd0, 32'h0);
    chk("resweep_hz3", {31'h0, obs_hz[1]}, 32'h0);
    chk("resweep_ready", {31'h0, bus.ready}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, register address width; depth = 2**ADDRESS_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register width (minimum 16).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have ports, one per line:
  clk  in  1  single clock; all state changes on rising edge.
  rst  in  1  reset, asynchronous, active-high.
  WE3  in  3  write mode: 000 none, 001 word, 010 lh, 011 lb, 110 lhu, 111 lbu; 100/101 none.
  A3  in  ADDRESS_WIDTH  write address.
  WD3  in  DATA_WIDTH  write data, pre-extension.
  RA  in  NUM_RD*ADDRESS_WIDTH  packed read addresses; port k at slice k.
  RD  out  NUM_RD*DATA_WIDTH  packed read data.
  hazard  out  NUM_RD  port k reads a register with a pending load.
  sb_set  in  1  mark register sb_addr pending (load issued).
  sb_addr  in  ADDRESS_WIDTH  register to mark pending.
  ready  out  1  clear sweep finished; block accepts writes.
  a0  out  DATA_WIDTH  debug view of register 10.

Function
REQ-005 SHALL implement FSM states CLEAR and RUN; CLEAR -> RUN after the sweep; RUN holds until rst.
REQ-006 In CLEAR, SHALL write zero to register idx each cycle, idx counting 0 to 2**ADDRESS_WIDTH-1, then enter RUN; sweep lasts exactly 2**ADDRESS_WIDTH cycles after rst deasserts.
REQ-007 SHALL drive ready = 1 only in RUN; WE3 and sb_set SHALL be ignored in CLEAR.
REQ-008 In RUN, SHALL write the extended WD3 to register A3 on the rising edge when WE3 is a write mode and A3 != 0.
REQ-009 Extension SHALL be: word = WD3; lh = sign-extend WD3[15:0]; lb = sign-extend WD3[7:0]; lhu/lbu = zero-extend same fields.
REQ-010 Register 0 SHALL read as 0 always; writes to it SHALL have no effect.
REQ-011 Reads SHALL be combinational; when a read address equals A3 with a valid write the same cycle, RD SHALL return the extended WD3 (write-through bypass).
REQ-012 RD SHALL be 0 on all ports while ready = 0.
REQ-013 a0 SHALL follow register 10 with the same bypass and ready rules as RD.
REQ-014 SHALL hold a busy bit per register; sb_set (RUN, sb_addr != 0) sets busy[sb_addr] on the next edge.
REQ-015 A valid write to A3 SHALL clear busy[A3] on the next edge.
REQ-016 If sb_set and a write target the same register in one cycle, set SHALL win (busy = 1).
REQ-017 hazard[k] SHALL be busy[RA_k] AND NOT (valid write to RA_k this cycle); address 0 never hazards.
REQ-018 Read ports SHALL be independent; identical addresses on several ports SHALL return identical data.

Reset
REQ-019 rst SHALL asynchronously force state CLEAR, idx 0, all busy bits 0, ready 0.
REQ-020 rst asserted mid-sweep or in RUN SHALL restart the full sweep after deassertion.
REQ-021 Array contents SHALL NOT be reset asynchronously; zeroing is by the sweep only.

Structure
REQ-022 Write-mode encodings (WE3 values) SHALL be an enum in the shared CPU package, shared with the load/store unit.
REQ-023 Extension logic SHALL be sub-module load_ext (mode + data in, extended data out), reused by the bypass path.
REQ-024 FSM state type SHALL be local to regfile_sb.

Verification
REQ-025 Reset: pulse rst, release -> ready 0 for exactly 32 cycles, then 1; all RD = 0 and hazard = 0 throughout.
REQ-026 Extension: write WD3 = 0x0000_8081 to x5 with lb, lbu, lh, lhu, word in turn -> RD reads 0xFFFF_FF81, 0x0000_0081, 0xFFFF_8081, 0x0000_8081, 0x0000_8081.
REQ-027 x0/bypass: write 0xDEAD_BEEF to x0 -> RD(x0) = 0; write 0x1234_5678 to x7 with RA0 = 7 same cycle -> RD0 = 0x1234_5678 before the edge.
REQ-028 Scoreboard: sb_set x9; next cycle RA1 = 9 -> hazard[1] = 1; word-write x9 -> hazard[1] = 0 that cycle, busy clear next; sb_set and write to x9 together -> hazard stays 1.
REQ-029 Reset mid-operation: write x10 = 5, sb_set x3, assert rst at sweep cycle 10 -> a0 = 0, busy clear, full 32-cycle sweep repeats.
REQ-030 Ignored in CLEAR: WE3 = word to x4 and sb_set x4 during sweep -> after ready, RD(x4) = 0 and hazard = 0.
